// File: rtl/mfp_srec_pkg.sv
// Shared definitions for the S-record loader: FSM states, ASCII constants and record-type decode.
// Checksum checking is built only when MFP_SREC_CHECKSUM_EN is defined (see mfp_srec_loader).
package mfp_srec_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_TYPE, ST_COUNT_HI, ST_COUNT_LO, ST_ADDR, ST_DATA_HI, ST_DATA_LO,
    ST_CSUM_HI, ST_CSUM_LO, ST_EOL, ST_EOL2
  } srec_state_e;

  typedef enum logic [1:0] {REC_HEADER, REC_DATA, REC_COUNT, REC_TERM} rec_class_e;

  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;
  localparam logic [7:0] CHAR_S      = 8'h53;
  localparam logic [7:0] CHAR_0      = 8'h30;
  localparam logic [7:0] CHAR_3      = 8'h33;
  localparam logic [7:0] CHAR_5      = 8'h35;
  localparam logic [7:0] CHAR_7      = 8'h37;
  localparam logic [7:0] CHAR_9      = 8'h39;
  localparam logic [7:0] CHAR_UPPER_A = 8'h41;
  localparam logic [7:0] CHAR_UPPER_F = 8'h46;
  localparam logic [7:0] CHAR_LOWER_A = 8'h61;
  localparam logic [7:0] CHAR_LOWER_F = 8'h66;

  function automatic logic type_char_ok(input logic [7:0] c);
    return (c >= CHAR_0 && c <= CHAR_3) || (c == CHAR_5) || (c >= CHAR_7 && c <= CHAR_9);
  endfunction

  function automatic logic [3:0] addr_nibbles(input logic [3:0] rec_type);
    case (rec_type)
      4'd2, 4'd8: return 4'd6;
      4'd3, 4'd7: return 4'd8;
      default:    return 4'd4;
    endcase
  endfunction

  function automatic rec_class_e rec_class(input logic [3:0] rec_type);
    case (rec_type)
      4'd1, 4'd2, 4'd3: return REC_DATA;
      4'd5:             return REC_COUNT;
      4'd7, 4'd8, 4'd9: return REC_TERM;
      default:          return REC_HEADER;
    endcase
  endfunction

endpackage

// File: rtl/mfp_srec_hex_decode.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module mfp_srec_hex_decode
  import mfp_srec_pkg::*;
(
  input  logic [7:0] char_i,
  output logic [3:0] nibble_o,
  output logic       hex_valid_o
);

  always_comb begin
    nibble_o    = 4'h0;
    hex_valid_o = 1'b0;
    if (char_i >= CHAR_0 && char_i <= CHAR_9) begin
      nibble_o    = 4'(char_i - CHAR_0);
      hex_valid_o = 1'b1;
    end else if (char_i >= CHAR_UPPER_A && char_i <= CHAR_UPPER_F) begin
      nibble_o    = 4'(char_i - CHAR_UPPER_A + 8'd10);
      hex_valid_o = 1'b1;
    end else if (char_i >= CHAR_LOWER_A && char_i <= CHAR_LOWER_F) begin
      nibble_o    = 4'(char_i - CHAR_LOWER_A + 8'd10);
      hex_valid_o = 1'b1;
    end
  end

endmodule

// File: rtl/mfp_srec_loader.sv
// S-record parser: packs S1/S2/S3 data into WORD_BYTES-wide writes and reports the entry address.
// Define MFP_SREC_CHECKSUM_EN to accumulate and verify record checksums.
module mfp_srec_loader
  import mfp_srec_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int LOC_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              char_data,
  input  logic                    char_ready,
  output logic                    in_progress,
  output logic                    load_done,
  output logic [31:0]             entry_address,
  output logic                    format_error,
  output logic                    checksum_error,
  output logic [LOC_W-1:0]        error_location,
  output logic [31:0]             write_address,
  output logic [8*WORD_BYTES-1:0] write_data,
  output logic [WORD_BYTES-1:0]   write_byte_en,
  output logic                    write_enable,
  output logic [3:0]              debug_state
);

  srec_state_e state_q, state_d;
  logic [3:0]  type_q, type_d, hi_q, hi_d;
  logic [2:0]  nib_cnt_q, nib_cnt_d;
  logic [7:0]  bytes_left_q, bytes_left_d;
  logic [31:0] addr_q, addr_d, entry_q, entry_d, wr_addr_q, wr_addr_d;
  logic [8*WORD_BYTES-1:0] buf_data_q, buf_data_d, wr_data_q, wr_data_d, new_data;
  logic [WORD_BYTES-1:0]   buf_be_q, buf_be_d, wr_be_q, wr_be_d, new_be;
  logic        wr_en_q, wr_en_d, in_prog_q, in_prog_d, done_q, done_d, fmt_err_q, fmt_err_d;
  logic [LOC_W-1:0] loc_q, loc_d;
  logic [3:0]  nibble, an;
  logic        hex_valid, bad, csum_bad, frozen, emit;
  logic [7:0]  byte_val, addr_bytes;
  int          lane, pos;

  mfp_srec_hex_decode u_hex (
    .char_i      (char_data),
    .nibble_o    (nibble),
    .hex_valid_o (hex_valid)
  );

  assign byte_val   = {hi_q, nibble};
  assign an         = addr_nibbles(type_q);
  assign addr_bytes = {5'd0, an[3:1]};
  assign lane       = int'(addr_q & 32'(WORD_BYTES - 1));
  assign pos        = BIG_ENDIAN ? (WORD_BYTES - 1 - lane) : lane;
  assign emit       = (lane == WORD_BYTES - 1) || (bytes_left_q == 8'd1);

`ifdef MFP_SREC_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       csum_err_q;

  // The running sum restarts at the count byte; a record is good when sum + checksum == 0xFF.
  always_comb begin
    sum_d    = sum_q;
    csum_bad = 1'b0;
    if (char_ready && !frozen && hex_valid) begin
      case (state_q)
        ST_COUNT_LO: sum_d = byte_val;
        ST_ADDR:     if (!nib_cnt_q[0]) sum_d = sum_q + {addr_q[3:0], nibble};
        ST_DATA_LO:  sum_d = sum_q + byte_val;
        ST_CSUM_LO:  csum_bad = ((sum_q + byte_val) != 8'hFF);
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q      <= 8'h00;
      csum_err_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      csum_err_q <= csum_err_q | csum_bad;
    end
  end

  assign checksum_error = csum_err_q;
  assign frozen         = fmt_err_q | csum_err_q;
`else
  assign csum_bad       = 1'b0;
  assign checksum_error = 1'b0;
  assign frozen         = fmt_err_q;
`endif

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    hi_d         = hi_q;
    nib_cnt_d    = nib_cnt_q;
    bytes_left_d = bytes_left_q;
    addr_d       = addr_q;
    buf_data_d   = buf_data_q;
    buf_be_d     = buf_be_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_be_d      = wr_be_q;
    in_prog_d    = in_prog_q;
    done_d       = 1'b0;
    entry_d      = entry_q;
    loc_d        = loc_q;
    bad          = 1'b0;
    new_data     = buf_data_q;
    new_be       = buf_be_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i == pos) begin
        new_data[i*8 +: 8] = byte_val;
        new_be[i]          = 1'b1;
      end
    end

    if (char_ready && !frozen) begin
      case (state_q)
        ST_IDLE: begin
          if (char_data == CHAR_S) state_d = ST_TYPE;
          else if (char_data != CHAR_CR && char_data != CHAR_LF) bad = 1'b1;
        end
        ST_TYPE: begin
          if (type_char_ok(char_data)) begin
            type_d  = char_data[3:0];
            state_d = ST_COUNT_HI;
            if (rec_class(char_data[3:0]) == REC_DATA) in_prog_d = 1'b1;
          end else bad = 1'b1;
        end
        ST_COUNT_HI, ST_DATA_HI, ST_CSUM_HI: begin
          if (hex_valid) begin
            hi_d    = nibble;
            state_d = srec_state_e'(state_q + 4'd1);
          end else bad = 1'b1;
        end
        ST_COUNT_LO: begin
          if (!hex_valid || byte_val < addr_bytes + 8'd1) bad = 1'b1;
          else begin
            bytes_left_d = byte_val - addr_bytes - 8'd1;
            nib_cnt_d    = an[2:0] - 3'd1;
            addr_d       = 32'h0;
            state_d      = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (hex_valid) begin
            addr_d = {addr_q[27:0], nibble};
            if (nib_cnt_q == 3'd0) state_d = (bytes_left_q != 8'd0) ? ST_DATA_HI : ST_CSUM_HI;
            else nib_cnt_d = nib_cnt_q - 3'd1;
          end else bad = 1'b1;
        end
        ST_DATA_LO: begin
          if (hex_valid) begin
            bytes_left_d = bytes_left_q - 8'd1;
            state_d      = (bytes_left_q == 8'd1) ? ST_CSUM_HI : ST_DATA_HI;
            addr_d       = addr_q + 32'd1;
            if (rec_class(type_q) == REC_DATA) begin
              // A word is issued when its top lane fills or the record runs out of data.
              if (emit) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = addr_q & ~32'(WORD_BYTES - 1);
                wr_data_d  = new_data;
                wr_be_d    = new_be;
                buf_data_d = '0;
                buf_be_d   = '0;
              end else begin
                buf_data_d = new_data;
                buf_be_d   = new_be;
              end
            end
          end else bad = 1'b1;
        end
        ST_CSUM_LO: begin
          if (!hex_valid) bad = 1'b1;
          else if (!csum_bad) begin
            state_d = ST_EOL;
            if (rec_class(type_q) == REC_TERM) entry_d = addr_q;
          end
        end
        ST_EOL, ST_EOL2: begin
          if (char_data == CHAR_CR && state_q == ST_EOL) state_d = ST_EOL2;
          else if (char_data == CHAR_LF) begin
            state_d = ST_IDLE;
            if (rec_class(type_q) == REC_TERM) begin
              done_d    = 1'b1;
              in_prog_d = 1'b0;
            end
          end else bad = 1'b1;
        end
        default: bad = 1'b1;
      endcase
      if (!bad && !csum_bad && loc_q != '1) loc_d = loc_q + LOC_W'(1);
    end
    fmt_err_d = fmt_err_q | bad;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      type_q       <= 4'h0;
      hi_q         <= 4'h0;
      nib_cnt_q    <= 3'd0;
      bytes_left_q <= 8'd0;
      addr_q       <= 32'h0;
      buf_data_q   <= '0;
      buf_be_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 32'h0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      in_prog_q    <= 1'b0;
      done_q       <= 1'b0;
      entry_q      <= 32'h0;
      fmt_err_q    <= 1'b0;
      loc_q        <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      hi_q         <= hi_d;
      nib_cnt_q    <= nib_cnt_d;
      bytes_left_q <= bytes_left_d;
      addr_q       <= addr_d;
      buf_data_q   <= buf_data_d;
      buf_be_q     <= buf_be_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
      in_prog_q    <= in_prog_d;
      done_q       <= done_d;
      entry_q      <= entry_d;
      fmt_err_q    <= fmt_err_d;
      loc_q        <= loc_d;
    end
  end

  assign in_progress    = in_prog_q;
  assign load_done      = done_q;
  assign entry_address  = entry_q;
  assign format_error   = fmt_err_q;
  assign error_location = loc_q;
  assign write_address  = wr_addr_q;
  assign write_data     = wr_data_q;
  assign write_byte_en  = wr_be_q;
  assign write_enable   = wr_en_q;
  assign debug_state    = state_q;

endmodule
